// File: rtl/sar_result_fifo.sv
// sar_result_fifo: captures SAR conversion codes, averages 2^AVG_LOG2 samples,
// and queues results in a show-ahead FIFO with back-pressure and sticky overflow.
// Ports: clk, rest (sync active-high), conv_done/code in, rd_en in,
// rd_data/rd_valid/full/level/ovf/sar_ena out.
// Optional macro SAR_AVG_ROUND_EN selects round-half-up averaging.
module sar_result_fifo #(
  parameter int AVG_LOG2 = 2,
  parameter int DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rest,
  input  logic       conv_done,
  input  logic [5:0] code,
  input  logic       rd_en,
  output logic [5:0] rd_data,
  output logic       rd_valid,
  output logic       full,
  output logic [3:0] level,
  output logic       ovf,
  output logic       sar_ena
);

  localparam int AW = 6 + AVG_LOG2;
  localparam int SW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SW-1:0] SLAST = SW'((1 << AVG_LOG2) - 1);
  localparam logic [3:0] LDEPTH = 4'(DEPTH);
`ifdef SAR_AVG_ROUND_EN
  localparam logic [AW:0] RND = (AW+1)'((1 << AVG_LOG2) >> 1);
`else
  localparam logic [AW:0] RND = '0;
`endif

  logic [AW-1:0] acc_q, acc_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [3:0]    level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          ena_q, ena_d;
  logic [5:0]    rd_data_q, rd_data_d;
  logic [5:0]    mem_q [DEPTH];
  logic [5:0]    mem_d [DEPTH];

  logic [AW:0]   sum;
  logic [5:0]    res;
  logic          push;
  logic          pop;
  logic          push_ok;
  logic [3:0]    left;
  logic [PW-1:0] rptr_inc;

  // With AVG_LOG2=0 scnt is a constant 0 and every sample is the last one.
  always_comb begin
    sum  = {1'b0, acc_q} + (AW+1)'(code) + RND;
    res  = 6'(sum >> AVG_LOG2);
    push = conv_done && (scnt_q == SLAST);
    acc_d  = acc_q;
    scnt_d = scnt_q;
    if (conv_done) begin
      if (push) begin
        acc_d  = '0;
        scnt_d = '0;
      end else begin
        acc_d  = acc_q + AW'(code);
        scnt_d = scnt_q + SW'(1);
      end
    end
  end

  always_comb begin
    pop      = rd_en && (level_q != 4'd0);
    push_ok  = push && ((level_q != LDEPTH) || pop);
    left     = level_q - {3'b000, pop};
    rptr_inc = rptr_q + PW'(1);
    wptr_d   = wptr_q;
    rptr_d   = pop ? rptr_inc : rptr_q;
    mem_d    = mem_q;
    ovf_d    = ovf_q || (push && !push_ok);
    level_d  = left + {3'b000, push_ok};
    if (push_ok) begin
      mem_d[wptr_q] = res;
      wptr_d        = wptr_q + PW'(1);
    end
    ena_d = level_d < LDEPTH;
    // Head register: the new push lands directly when nothing else remains.
    rd_data_d = rd_data_q;
    if (left == 4'd0) begin
      if (push_ok) rd_data_d = res;
    end else if (pop) begin
      rd_data_d = mem_q[rptr_inc];
    end
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      acc_q     <= '0;
      scnt_q    <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
      ena_q     <= 1'b0;
      rd_data_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      acc_q     <= acc_d;
      scnt_q    <= scnt_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
      ena_q     <= ena_d;
      rd_data_q <= rd_data_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = level_q != 4'd0;
  assign full     = level_q == LDEPTH;
  assign level    = level_q;
  assign ovf      = ovf_q;
  assign sar_ena  = ena_q;

endmodule

// File: tb/tb_sar_result_fifo.sv
// tb_sar_result_fifo: directed + random check of two sar_result_fifo builds
// (u0: AVG_LOG2=2, u1: AVG_LOG2=0) against a queue-based reference model.
module tb_sar_result_fifo;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rest;
  logic [1:0] cd, rd;
  logic [5:0] code [2];
  logic [5:0] rdat [2];
  logic [3:0] lvl [2];
  logic [1:0] vld, ful, ovf, ena;

  int total = 0;
  int bad = 0;

  int msum [2];
  int mcnt [2];
  int mhead [2];
  bit movf [2];
  bit mena [2];
  int mq [2][$];

  always #5 clk = ~clk;

  sar_result_fifo #(.AVG_LOG2(2), .DEPTH(DEPTH)) u0 (
    .clk(clk), .rest(rest), .conv_done(cd[0]), .code(code[0]),
    .rd_en(rd[0]), .rd_data(rdat[0]), .rd_valid(vld[0]), .full(ful[0]),
    .level(lvl[0]), .ovf(ovf[0]), .sar_ena(ena[0]));

  sar_result_fifo #(.AVG_LOG2(0), .DEPTH(DEPTH)) u1 (
    .clk(clk), .rest(rest), .conv_done(cd[1]), .code(code[1]),
    .rd_en(rd[1]), .rd_data(rdat[1]), .rd_valid(vld[1]), .full(ful[1]),
    .level(lvl[1]), .ovf(ovf[1]), .sar_ena(ena[1]));

  function automatic int avg_of(int k, int s);
    int a;
    int r;
    a = (k == 0) ? 2 : 0;
    r = 0;
`ifdef SAR_AVG_ROUND_EN
    if (a > 0) r = (2 ** a) / 2;
`endif
    return (s + r) / (2 ** a);
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      bit p;
      int v;
      int n;
      n = (k == 0) ? 4 : 1;
      if (rest) begin
        msum[k] = 0; mcnt[k] = 0; mhead[k] = 0;
        movf[k] = 0; mena[k] = 0;
        mq[k].delete();
      end else begin
        p = 0;
        v = 0;
        if (cd[k]) begin
          msum[k] += int'(code[k]);
          mcnt[k]++;
          if (mcnt[k] == n) begin
            p = 1;
            v = avg_of(k, msum[k]);
            msum[k] = 0;
            mcnt[k] = 0;
          end
        end
        if (rd[k] && mq[k].size() > 0) void'(mq[k].pop_front());
        if (p) begin
          if (mq[k].size() < DEPTH) mq[k].push_back(v);
          else movf[k] = 1;
        end
        mena[k] = mq[k].size() < DEPTH;
        if (mq[k].size() > 0) mhead[k] = mq[k][0];
      end
    end
  endtask

  task automatic chk(string tag, int obs, int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d level", k), int'(lvl[k]), mq[k].size());
      chk($sformatf("u%0d rd_valid", k), int'(vld[k]), int'(mq[k].size() > 0));
      chk($sformatf("u%0d full", k), int'(ful[k]), int'(mq[k].size() == DEPTH));
      chk($sformatf("u%0d ovf", k), int'(ovf[k]), int'(movf[k]));
      chk($sformatf("u%0d sar_ena", k), int'(ena[k]), int'(mena[k]));
      chk($sformatf("u%0d rd_data", k), int'(rdat[k]), mhead[k]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic step(int k, bit c, int v, bit r);
    cd = '0;
    rd = '0;
    code[0] = '0;
    code[1] = '0;
    cd[k] = c;
    code[k] = 6'(v);
    rd[k] = r;
    tick();
  endtask

  initial begin
    int seq [4];
    rest = 1'b1;
    cd = '0;
    rd = '0;
    code[0] = '0;
    code[1] = '0;
    for (int i = 0; i < DEPTH; i++) msum[i % 2] = 0;

    // reset with conv_done toggling
    cd = 2'b11; code[0] = 6'd33; code[1] = 6'd44;
    tick();
    cd = 2'b00;
    tick();
    chk("reset sar_ena", int'(ena[0]), 0);
    chk("reset rd_data", int'(rdat[1]), 0);
    rest = 1'b0;
    step(0, 0, 0, 0);
    chk("release sar_ena", int'(ena[0] & ena[1]), 1);

    // averaging 10,11,11,11
    step(0, 1, 10, 0);
    step(0, 1, 11, 0);
    step(0, 1, 11, 0);
    chk("avg pre valid", int'(vld[0]), 0);
    step(0, 1, 11, 0);
`ifdef SAR_AVG_ROUND_EN
    chk("avg result", int'(rdat[0]), 11);
`else
    chk("avg result", int'(rdat[0]), 10);
`endif
    step(0, 0, 0, 1);

    // fill and overflow on raw instance
    for (int i = 5; i <= 8; i++) step(1, 1, i, 0);
    chk("fill full", int'(ful[1]), 1);
    chk("fill sar_ena", int'(ena[1]), 0);
    step(1, 1, 9, 0);
    chk("fill ovf", int'(ovf[1]), 1);
    chk("fill head", int'(rdat[1]), 5);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1);
    chk("drain ovf sticky", int'(ovf[1]), 1);
    chk("drain last", int'(rdat[1]), 8);

    // simultaneous push+pop at full
    rest = 1'b1;
    step(1, 0, 0, 0);
    rest = 1'b0;
    for (int i = 1; i <= 4; i++) step(1, 1, i, 0);
    step(1, 1, 9, 1);
    chk("pp level", int'(lvl[1]), 4);
    chk("pp ovf", int'(ovf[1]), 0);
    seq = '{2, 3, 4, 9};
    for (int i = 0; i < 4; i++) begin
      chk("pp order", int'(rdat[1]), seq[i]);
      step(1, 0, 0, 1);
    end

    // reset mid-accumulation
    step(0, 1, 20, 0);
    step(0, 1, 20, 0);
    rest = 1'b1;
    step(0, 0, 0, 0);
    rest = 1'b0;
    for (int i = 0; i < 4; i++) step(0, 1, 63, 0);
    chk("midrst level", int'(lvl[0]), 1);
    chk("midrst data", int'(rdat[0]), 63);

    // empty read then push
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1);
    chk("empty level", int'(lvl[1]), 0);
    step(1, 1, 17, 0);
    chk("empty push", int'(rdat[1]), 17);
    step(1, 0, 0, 1);

    // random traffic on both instances
    for (int i = 0; i < 600; i++) begin
      rest = ($urandom_range(0, 149) == 0);
      for (int k = 0; k < 2; k++) begin
        cd[k] = ($urandom_range(0, 9) < 5);
        code[k] = 6'($urandom_range(0, 63));
        rd[k] = ($urandom_range(0, 9) < 3);
      end
      tick();
    end
    rest = 1'b0;
    cd = '0;
    rd = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
